// File: rtl/instruction_mem_loadable.sv
// instruction_mem_loadable
// Fetch-stage instruction memory. It has a registered fetch path with stall
// hold, flush and fault reporting, and a streaming boot-load FSM that fills
// the memory word by word through a valid/ready handshake.
module instruction_mem_loadable #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        req_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        loading,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        fault
);

    // Derived word-index width; not meant to be overridden.
    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    // Storage: one write port (load) and one synchronous read port (fetch).
    logic [31:0] mem [DEPTH_WORDS];

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   load_ptr_q, load_ptr_d;
    logic [31:0]         instr_pc_q, instr_pc_d;
    logic                instr_valid_q, instr_valid_d;
    logic                fault_q, fault_d;
    logic                nop_sel_q, nop_sel_d;
    logic [31:0]         rd_data_q;

    logic [31:0]         diff_s;
    logic [29:0]         offset_s;
    logic                bad_pc_s;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic                rd_en_s;
    logic                wr_en_s;
    logic                load_done_s;

    // Address decode: the full 32-bit offset is range-checked before it is
    // narrowed to the word index, so high pc bits can never alias.
    always_comb begin
        diff_s    = pc - BASE_ADDR;
        offset_s  = diff_s[31:2];
        bad_pc_s  = (diff_s[1:0] != 2'b00) || (pc < BASE_ADDR) ||
                    (offset_s >= 30'(DEPTH_WORDS));
        rd_addr_s = offset_s[ADDR_W-1:0];
    end

    // Load completion: explicit last word or the final memory slot (no wrap).
    always_comb begin
        load_done_s = load_last || (load_ptr_q == ADDR_W'(DEPTH_WORDS - 1));
    end

    // Next-state logic for the mode FSM and the fetch output registers.
    always_comb begin
        state_d       = state_q;
        load_ptr_d    = load_ptr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;
        nop_sel_d     = nop_sel_q;
        rd_en_s       = 1'b0;
        wr_en_s       = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (load_start) begin
                    // Entering LOAD beats every fetch input this cycle.
                    state_d       = ST_LOAD;
                    load_ptr_d    = ADDR_W'(0);
                    instr_valid_d = 1'b0;
                    fault_d       = 1'b0;
                end else if (flush) begin
                    nop_sel_d     = 1'b1;
                    instr_valid_d = 1'b0;
                    fault_d       = 1'b0;
                end else if (stall) begin
                    // Hold every fetch output exactly, valid and fault included.
                    instr_valid_d = instr_valid_q;
                    fault_d       = fault_q;
                end else if (req_valid) begin
                    instr_pc_d    = pc;
                    instr_valid_d = 1'b1;
                    if (bad_pc_s) begin
                        nop_sel_d = 1'b1;
                        fault_d   = 1'b1;
                    end else begin
                        nop_sel_d = 1'b0;
                        fault_d   = 1'b0;
                        rd_en_s   = 1'b1;
                    end
                end else begin
                    // Idle: instr and instr_pc hold, status clears.
                    instr_valid_d = 1'b0;
                    fault_d       = 1'b0;
                end
            end
            ST_LOAD: begin
                instr_valid_d = 1'b0;
                fault_d       = 1'b0;
                if (load_valid) begin
                    wr_en_s    = 1'b1;
                    load_ptr_d = load_ptr_q + ADDR_W'(1);
                    if (load_done_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    load_ptr_d = load_ptr_q;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and fetch output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            load_ptr_q    <= ADDR_W'(0);
            instr_pc_q    <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            nop_sel_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            load_ptr_q    <= load_ptr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
            nop_sel_q     <= nop_sel_d;
        end
    end

    // Write port: an accepted load word goes to the current load pointer.
    always_ff @(posedge clk) begin
        if (wr_en_s && rst) begin
            mem[load_ptr_q] <= load_data;
        end
    end

    // Read port: a plain registered read so the array maps onto block RAM;
    // the data register holds while no good fetch is issued.
    always_ff @(posedge clk) begin
        if (rd_en_s && rst) begin
            rd_data_q <= mem[rd_addr_s];
        end
    end

    // Output drive: every term comes straight from a register.
    always_comb begin
        instr       = nop_sel_q ? NOP_INSTR : rd_data_q;
        instr_pc    = instr_pc_q;
        instr_valid = instr_valid_q;
        fault       = fault_q;
        loading     = (state_q == ST_LOAD);
        load_ready  = (state_q == ST_LOAD);
    end

endmodule

// File: tb/tb_instruction_mem_loadable.sv
// Self-checking bench for instruction_mem_loadable: a default instance for the
// table-driven fetch vectors and load sequences, and a small 4-word instance
// based at 0x1000 for the base-offset and overflow corner cases.
module tb_instruction_mem_loadable;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;

    // Default instance signals.
    logic [31:0] pc, load_data, instr, instr_pc;
    logic        req_valid, stall, flush, load_start, load_valid, load_last;
    logic        load_ready, loading, instr_valid, fault;

    // Small instance signals.
    logic [31:0] pc1, load_data1, instr1, instr_pc1;
    logic        req_valid1, load_start1, load_valid1, load_last1;
    logic        load_ready1, loading1, instr_valid1, fault1;

    int n_vec;
    int n_err;

    instruction_mem_loadable dut (
        .clk(clk), .rst(rst), .pc(pc), .req_valid(req_valid), .stall(stall),
        .flush(flush), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .loading(loading), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .fault(fault)
    );

    instruction_mem_loadable #(
        .DEPTH_WORDS(4),
        .BASE_ADDR(32'h0000_1000)
    ) dut1 (
        .clk(clk), .rst(rst), .pc(pc1), .req_valid(req_valid1), .stall(1'b0),
        .flush(1'b0), .load_start(load_start1), .load_valid(load_valid1),
        .load_data(load_data1), .load_last(load_last1), .load_ready(load_ready1),
        .loading(loading1), .instr(instr1), .instr_pc(instr_pc1),
        .instr_valid(instr_valid1), .fault(fault1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic [31:0] e_instr;
        logic        chk_pc;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_fault;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] e_i, input logic e_f);
        req_valid = 1'b1;
        pc        = a;
        step();
        req_valid = 1'b0;
        chk("fetch_instr", instr, e_i);
        chk("fetch_pc", instr_pc, a);
        chk("fetch_valid", {31'b0, instr_valid}, 32'd1);
        chk("fetch_fault", {31'b0, fault}, {31'b0, e_f});
    endtask

    task automatic fetch1(input logic [31:0] a, input logic [31:0] e_i, input logic e_f);
        req_valid1 = 1'b1;
        pc1        = a;
        step();
        req_valid1 = 1'b0;
        if (!e_f) chk("b_fetch_instr", instr1, e_i);
        else      chk("b_fetch_nop", instr1, NOP);
        chk("b_fetch_valid", {31'b0, instr_valid1}, 32'd1);
        chk("b_fetch_fault", {31'b0, fault1}, {31'b0, e_f});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0; pc = 32'h0; req_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_data = 32'h0; load_last = 1'b0;
        pc1 = 32'h0; req_valid1 = 1'b0; load_start1 = 1'b0; load_valid1 = 1'b0;
        load_data1 = 32'h0; load_last1 = 1'b0;

        // Fetch vectors, applied after the 3-word image is loaded.
        //            req   pc             stl   fl    instr          cpc   e_pc           v     f
        tbl[0]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'hAAAA_0001, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'hAAAA_0002, 1'b1, 32'h0000_0004, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'hAAAA_0003, 1'b1, 32'h0000_0008, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'hAAAA_0003, 1'b1, 32'h0000_0008, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'hAAAA_0002, 1'b1, 32'h0000_0004, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 32'h0000_0008, 1'b1, 1'b0, 32'hAAAA_0002, 1'b1, 32'h0000_0004, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 32'h0000_000C, 1'b1, 1'b0, 32'hAAAA_0002, 1'b1, 32'h0000_0004, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'hAAAA_0002, 1'b1, 32'h0000_0004, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b1, NOP,           1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'h0000_0002, 1'b0, 1'b0, NOP,           1'b1, 32'h0000_0002, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 32'h0000_0008, 1'b1, 1'b0, NOP,           1'b1, 32'h0000_0002, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 32'h0000_0400, 1'b0, 1'b0, NOP,           1'b1, 32'h0000_0400, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, NOP,           1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'hAAAA_0003, 1'b1, 32'h0000_0008, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, NOP,           1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, NOP,           1'b0, 32'h0000_0000, 1'b0, 1'b0};

        // Reset for two cycles.
        step();
        step();
        rst = 1'b1;
        chk("rst_instr", instr, NOP);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_loading", {31'b0, loading}, 32'd0);
        chk("rst_ready", {31'b0, load_ready}, 32'd0);
        chk("rst_pc", instr_pc, 32'h0);

        // Three-word load with gaps between valid words.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("load_enter", {31'b0, loading}, 32'd1);
        chk("load_ready", {31'b0, load_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hAAAA_0001 + i;
            load_last  = (i == 2);
            step();
            load_valid = 1'b0;
            load_last  = 1'b0;
            if (i < 2) begin
                step();
                chk("load_gap_loading", {31'b0, loading}, 32'd1);
            end
        end
        chk("load_exit", {31'b0, loading}, 32'd0);

        // Table-driven fetch vectors.
        for (int i = 0; i < 16; i++) begin
            req_valid = tbl[i].req;
            pc        = tbl[i].pc;
            stall     = tbl[i].stall;
            flush     = tbl[i].flush;
            step();
            chk($sformatf("vec%0d_instr", i), instr, tbl[i].e_instr);
            if (tbl[i].chk_pc) chk($sformatf("vec%0d_pc", i), instr_pc, tbl[i].e_pc);
            chk($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].e_valid});
            chk($sformatf("vec%0d_fault", i), {31'b0, fault}, {31'b0, tbl[i].e_fault});
        end
        req_valid = 1'b0; stall = 1'b0; flush = 1'b0;

        // load_start wins over a simultaneous fetch; fetches ignored in LOAD.
        fetch(32'h0000_0004, 32'hAAAA_0002, 1'b0);
        load_start = 1'b1;
        req_valid  = 1'b1;
        pc         = 32'h0000_0008;
        step();
        load_start = 1'b0;
        chk("ls_valid", {31'b0, instr_valid}, 32'd0);
        chk("ls_fault", {31'b0, fault}, 32'd0);
        chk("ls_loading", {31'b0, loading}, 32'd1);
        pc = 32'h0000_0002;
        step();
        chk("ld_fetch_valid", {31'b0, instr_valid}, 32'd0);
        chk("ld_fetch_fault", {31'b0, fault}, 32'd0);
        req_valid  = 1'b0;
        load_valid = 1'b1;
        load_last  = 1'b1;
        load_data  = 32'hAAAA_0001;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("ls_exit", {31'b0, loading}, 32'd0);

        // Stream DEPTH_WORDS+2 words without load_last.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 258; i++) begin
            if (i >= 256) chk("ovf_ready_low", {31'b0, load_ready}, 32'd0);
            load_valid = 1'b1;
            load_data  = 32'hB000_0000 + i;
            step();
            if (i == 254) chk("ovf_loading_255", {31'b0, loading}, 32'd1);
            if (i == 255) chk("ovf_loading_drop", {31'b0, loading}, 32'd0);
        end
        load_valid = 1'b0;
        fetch(32'h0000_0000, 32'hB000_0000, 1'b0);
        fetch(32'h0000_03FC, 32'hB000_00FF, 1'b0);

        // Reset in the middle of a load; a mid-load load_start is ignored.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hC000_0010 + i;
            load_start = (i == 2);
            step();
        end
        load_valid = 1'b0;
        load_start = 1'b0;
        chk("mid_loading", {31'b0, loading}, 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_rst_loading", {31'b0, loading}, 32'd0);
        chk("mid_rst_ready", {31'b0, load_ready}, 32'd0);
        fetch(32'h0000_0010, 32'hC000_0014, 1'b0);
        fetch(32'h0000_0008, 32'hC000_0012, 1'b0);
        fetch(32'h0000_0014, 32'hB000_0005, 1'b0);

        // Small instance: base offset, below-base pc, overflow stream.
        fetch1(32'h0000_0FFC, NOP, 1'b1);
        fetch1(32'h0000_1010, NOP, 1'b1);
        load_start1 = 1'b1;
        step();
        load_start1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("b_ready", {31'b0, load_ready1}, {31'b0, (i < 4)});
            load_valid1 = 1'b1;
            load_data1  = 32'hD000_0000 + i;
            step();
        end
        load_valid1 = 1'b0;
        chk("b_loading", {31'b0, loading1}, 32'd0);
        fetch1(32'h0000_1000, 32'hD000_0000, 1'b0);
        fetch1(32'h0000_100C, 32'hD000_0003, 1'b0);
        fetch1(32'h0000_1002, NOP, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
